// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stall, branch flush and data-memory wait FSM with timeout.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] IFID_RSaddr_i,
  input  logic [REG_AW-1:0] IFID_RTaddr_i,
  input  logic              IDEX_MemRead_i,
  input  logic [REG_AW-1:0] IDEX_RDaddr_i,
  input  logic              Branch_taken_i,
  input  logic              EXMEM_MemRead_i,
  input  logic              EXMEM_MemWrite_i,
  input  logic              dmem_ack_i,
  output logic              dmem_req_o,
  output logic              PC_write_o,
  output logic              IFID_write_o,
  output logic              IFID_flush_o,
  output logic              IDEX_write_o,
  output logic              IDEX_bubble_o,
  output logic              EXMEM_write_o,
  output logic              MEMWB_bubble_o,
  output logic              err_o,
  output logic [1:0]        state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  // Memory handshake: dmem_req_o is a level request that the requester holds until
  // dmem_ack_i is seen; an ack in the request cycle completes it with zero wait states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_acc;
  logic             mem_stall;
  logic             load_use;

  assign mem_acc    = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign dmem_req_o = ~rst_i & mem_acc & (state != ERR);
  assign mem_stall  = (dmem_req_o & ~dmem_ack_i) | (state == ERR);
  assign load_use   = IDEX_MemRead_i & (IDEX_RDaddr_i != '0) &
                      ((IDEX_RDaddr_i == IFID_RSaddr_i) | (IDEX_RDaddr_i == IFID_RTaddr_i));
  assign state_o    = state;

  always_comb begin
    PC_write_o     = 1'b1;
    IFID_write_o   = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_write_o   = 1'b1;
    IDEX_bubble_o  = 1'b0;
    EXMEM_write_o  = 1'b1;
    MEMWB_bubble_o = 1'b0;
    if (mem_stall) begin
      PC_write_o     = 1'b0;
      IFID_write_o   = 1'b0;
      IDEX_write_o   = 1'b0;
      EXMEM_write_o  = 1'b0;
      MEMWB_bubble_o = 1'b1;
    end else if (load_use) begin
      // Branch operands are stale here; ID re-resolves the branch next cycle.
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IDEX_bubble_o = 1'b1;
    end else begin
      IFID_flush_o = Branch_taken_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= '0;
          if (mem_stall) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            state    <= ERR;
            wait_cnt <= '0;
            err_o    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR: begin
          wait_cnt <= '0;
          err_o    <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((mem_stall | load_use) && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (IFID_flush_o && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MAX_WAIT=4); perf counters checked when HAZARD_PERF_EN is defined.
module tb_pipeline_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  // ctrl = {req, pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble, err}
  localparam logic [8:0] C_DEF   = 9'b0_1_1_0_1_0_1_0_0;
  localparam logic [8:0] C_LU    = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] C_FLUSH = 9'b0_1_1_1_1_0_1_0_0;
  localparam logic [8:0] C_STALL = 9'b1_0_0_0_0_0_0_1_0;
  localparam logic [8:0] C_REQOK = 9'b1_1_1_0_1_0_1_0_0;
  localparam logic [8:0] C_ERR   = 9'b0_0_0_0_0_0_0_1_1;
  localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2;

  logic clk = 1'b0;
  logic rst;
  logic [REG_AW-1:0] rs, rt, rd;
  logic idex_mr, br, exr, exw, ack;
  logic dmem_req, pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, err;
  logic [1:0] state;
  logic [8:0] ctrl;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MAX_WAIT(4), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .IFID_RSaddr_i(rs), .IFID_RTaddr_i(rt),
    .IDEX_MemRead_i(idex_mr), .IDEX_RDaddr_i(rd),
    .Branch_taken_i(br),
    .EXMEM_MemRead_i(exr), .EXMEM_MemWrite_i(exw),
    .dmem_ack_i(ack),
    .dmem_req_o(dmem_req), .PC_write_o(pc_w), .IFID_write_o(ifid_w), .IFID_flush_o(ifid_f),
    .IDEX_write_o(idex_w), .IDEX_bubble_o(idex_b), .EXMEM_write_o(exmem_w),
    .MEMWB_bubble_o(memwb_b), .err_o(err), .state_o(state)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
  );

  assign ctrl = {dmem_req, pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, err};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic a_mr,
                       input logic [4:0] a_rd, input logic a_br, input logic a_exr,
                       input logic a_exw, input logic a_ack);
    rs = a_rs; rt = a_rt; idex_mr = a_mr; rd = a_rd;
    br = a_br; exr = a_exr; exw = a_exw; ack = a_ack;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units later.
  task automatic expect_cycle(input string tag, input logic [8:0] exp_ctrl, input logic [1:0] exp_state);
    #4;
    check({tag, ".ctrl"}, 16'(ctrl), 16'(exp_ctrl));
    check({tag, ".state"}, 16'(state), 16'(exp_state));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    expect_cycle("rst_req_forced_off", C_DEF, S_RUN);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_cycle("idle", C_DEF, S_RUN);

    drive(5, 1, 1, 5, 0, 0, 0, 0);
    expect_cycle("lu_rs", C_LU, S_RUN);
    drive(5, 1, 0, 0, 0, 0, 0, 0);
    expect_cycle("lu_released", C_DEF, S_RUN);
    drive(3, 7, 1, 7, 0, 0, 0, 0);
    expect_cycle("lu_rt", C_LU, S_RUN);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    expect_cycle("lu_r0", C_DEF, S_RUN);
    drive(4, 6, 1, 9, 0, 0, 0, 0);
    expect_cycle("lu_nomatch", C_DEF, S_RUN);

    drive(1, 2, 0, 0, 1, 0, 0, 0);
    expect_cycle("branch", C_FLUSH, S_RUN);
    drive(5, 2, 1, 5, 1, 0, 0, 0);
    expect_cycle("branch_lu", C_LU, S_RUN);

    // Load waits 3 cycles, ack on the 4th request cycle.
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    expect_cycle("mw0", C_STALL, S_RUN);
    expect_cycle("mw1", C_STALL, S_WAIT);
    expect_cycle("mw2", C_STALL, S_WAIT);
    ack = 1'b1;
    expect_cycle("mw_ack", C_REQOK, S_WAIT);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_cycle("mw_done", C_DEF, S_RUN);

    drive(0, 0, 0, 0, 0, 0, 1, 1);
    expect_cycle("zero_wait", C_REQOK, S_RUN);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_cycle("zero_wait_after", C_DEF, S_RUN);

    // mem_stall outranks load_use and branch.
    drive(5, 5, 1, 5, 1, 1, 0, 0);
    expect_cycle("prio", C_STALL, S_RUN);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    expect_cycle("rst_in_wait", C_DEF, S_WAIT);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_cycle("after_rst_wait", C_DEF, S_RUN);

    // Timeout: one RUN stall cycle, then 4 MEM_WAIT cycles, then ERR.
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    expect_cycle("to_run", C_STALL, S_RUN);
    for (int i = 0; i < 4; i++) expect_cycle($sformatf("to_wait%0d", i), C_STALL, S_WAIT);
    expect_cycle("to_err", C_ERR, S_ERR);
    expect_cycle("to_err_sticky", C_ERR, S_ERR);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_cycle("err_cleared", C_DEF, S_RUN);

`ifdef HAZARD_PERF_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
    check("perf_rst_stall", stall_cnt, 16'd0);
    check("perf_rst_flush", flush_cnt, 16'd0);
    @(posedge clk); #1;
    drive(5, 0, 1, 5, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 6, 1, 6, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    ack = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    check("perf_stall", stall_cnt, 16'd5);
    check("perf_flush", flush_cnt, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule
